// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM state
// encodings and a constant log2 helper used for counter and pointer sizing.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO buffering received characters. The head entry and
// the empty flag are held in registers so the consumer sees clean outputs.
// A pop and a push in the same cycle on a full FIFO is accepted: the pop
// frees the slot that the push then fills.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = log2_ceil(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             full_now;
  logic             do_push;
  logic             do_pop;

  assign full_now = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Pointer/storage update and look-ahead of the next head entry.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_now || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    dout_d   = '0;
    if (!empty_d) dout_d = mem_d[rd_ptr_d[AW-1:0]];
  end

  // FIFO state registers; reset empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      mem_q    <= mem_d;
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_now;

endmodule

// File: rtl/uart_configurable.sv
// Full-duplex UART with parameterised frame format (data bits, parity, stop
// bits), a receive FIFO and sticky parity/framing/overrun flags. Transmit
// and receive state machines live here; buffering is in sync_fifo.
module uart_configurable
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ    = 125_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  input  logic                 err_clear
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = log2_ceil(SYMBOL_EDGE_TIME) + 1;
  localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SYMBOL_EDGE_TIME / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = (PARITY != PARITY_NONE);

  // Parity bit that makes the frame match the configured even/odd sense.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_parity_q, tx_parity_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 serial_out_q, serial_out_d;
  logic                 tx_sym_end;

  assign tx_sym_end    = (tx_cnt_q == SYM_LAST);
  assign data_in_ready = (tx_state_q == TX_IDLE);

  // TX next state: capture data on handshake, then walk the frame one symbol at a time.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_parity_d = tx_parity_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q + CW'(1);
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (data_in_valid) begin
          tx_state_d  = TX_START;
          tx_shift_d  = data_in;
          tx_parity_d = parity_of(data_in);
          tx_bit_d    = '0;
        end
      end
      TX_START: begin
        if (tx_sym_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_sym_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (HAS_PARITY) tx_state_d = TX_PARITY;
            else            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_sym_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_sym_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
          else                       tx_bit_d   = tx_bit_q + 4'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end
    endcase
    case (tx_state_d)
      TX_START:  serial_out_d = 1'b0;
      TX_DATA:   serial_out_d = tx_shift_d[0];
      TX_PARITY: serial_out_d = tx_parity_d;
      default:   serial_out_d = 1'b1;
    endcase
  end

  // TX registers; the line output is registered so the pin never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_shift_q   <= '0;
      tx_parity_q  <= 1'b0;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
      serial_out_q <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_shift_q   <= tx_shift_d;
      tx_parity_q  <= tx_parity_d;
      tx_bit_q     <= tx_bit_d;
      tx_cnt_q     <= tx_cnt_d;
      serial_out_q <= serial_out_d;
    end
  end

  assign serial_out = serial_out_q;

  // ---------------- receiver ----------------
  logic                 rx_sync1_q, rx_sync1_d;
  logic                 rx_sync2_q, rx_sync2_d;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                 rx_sym_end;
  logic                 rx_push;
  logic                 parity_evt;
  logic                 framing_evt;

  assign rx_sym_end = (rx_cnt_q == SYM_LAST);

  // Synchroniser chain for the asynchronous RX line plus edge-detect history.
  always_comb begin
    rx_sync1_d = serial_in;
    rx_sync2_d = rx_sync1_q;
    rx_prev_d  = rx_sync2_q;
  end

  // RX next state: find the start edge, sample mid-symbol, judge the frame at the first stop.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_bit_d    = rx_bit_q;
    rx_cnt_d    = rx_cnt_q + CW'(1);
    rx_push     = 1'b0;
    parity_evt  = 1'b0;
    framing_evt = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          if (rx_sync2_q) rx_state_d = RX_IDLE;
          else            rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sym_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d = '0;
            if (HAS_PARITY) rx_state_d = RX_PARITY;
            else            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sym_end) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync2_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sym_end) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_push     = 1'b1;
          framing_evt = !rx_sync2_q;
          parity_evt  = HAS_PARITY && (rx_par_q != parity_of(rx_shift_q));
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // RX registers; the synchroniser idles high like the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      rx_sync1_q <= rx_sync1_d;
      rx_sync2_q <= rx_sync2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_bit_q   <= rx_bit_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // ---------------- receive buffer and sticky flags ----------------
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic overrun_evt;
  logic parity_error_q, parity_error_d;
  logic framing_error_q, framing_error_d;
  logic overrun_q, overrun_d;

  assign data_out_valid = !fifo_empty;
  assign fifo_pop       = data_out_valid && data_out_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_shift_q),
    .dout  (data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flags: a new error event takes priority over a clear request.
  always_comb begin
    overrun_evt     = rx_push && fifo_full && !fifo_pop;
    parity_error_d  = parity_evt  ? 1'b1 : (err_clear ? 1'b0 : parity_error_q);
    framing_error_d = framing_evt ? 1'b1 : (err_clear ? 1'b0 : framing_error_q);
    overrun_d       = overrun_evt ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
  end

  // Flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_configurable.sv
// Directed bench for uart_configurable. Instance u_dut0 runs 8N1 at the real
// 125 MHz / 115200 rate; instance u_dut1 runs 8E1 with 16 clocks per bit so
// the multi-frame parity, overrun and framing cases stay short.
module tb_uart_configurable;

  localparam int SET1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       reset0, reset1;
  logic [7:0] data_in0, data_in1;
  logic       data_in_valid0, data_in_valid1;
  logic       data_in_ready0, data_in_ready1;
  logic [7:0] data_out0, data_out1;
  logic       data_out_valid0, data_out_valid1;
  logic       data_out_ready0, data_out_ready1;
  logic       serial_in0, serial_in1;
  logic       serial_out0, serial_out1;
  logic       parity_error0, parity_error1;
  logic       framing_error0, framing_error1;
  logic       overrun0, overrun1;
  logic       err_clear0, err_clear1;
  logic       loop0, loop1, drive0, drive1, flip1;
  int         lowCount;
  logic [10:0] frameBits;

  assign serial_in0 = loop0 ? serial_out0 : drive0;
  assign serial_in1 = loop1 ? (serial_out1 ^ flip1) : drive1;

  uart_configurable #(
    .CLOCK_FREQ(125_000_000), .BAUD_RATE(115_200), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .reset(reset0), .data_in(data_in0), .data_in_valid(data_in_valid0),
    .data_in_ready(data_in_ready0), .data_out(data_out0), .data_out_valid(data_out_valid0),
    .data_out_ready(data_out_ready0), .serial_in(serial_in0), .serial_out(serial_out0),
    .parity_error(parity_error0), .framing_error(framing_error0), .overrun(overrun0),
    .err_clear(err_clear0)
  );

  uart_configurable #(
    .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
  ) u_dut1 (
    .clk(clk), .reset(reset1), .data_in(data_in1), .data_in_valid(data_in_valid1),
    .data_in_ready(data_in_ready1), .data_out(data_out1), .data_out_valid(data_out_valid1),
    .data_out_ready(data_out_ready1), .serial_in(serial_in1), .serial_out(serial_out1),
    .parity_error(parity_error1), .framing_error(framing_error1), .overrun(overrun1),
    .err_clear(err_clear1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for TX ready, hand over one byte, then scramble data_in.
  task automatic applyStimulus(input int sel, input logic [7:0] value);
    int waited;
    logic rdy;
    waited = 0;
    @(negedge clk);
    rdy = (sel == 0) ? data_in_ready0 : data_in_ready1;
    while (rdy !== 1'b1 && waited < 30000) begin
      @(negedge clk);
      waited++;
      rdy = (sel == 0) ? data_in_ready0 : data_in_ready1;
    end
    checkOutput($sformatf("tx_ready_dut%0d", sel), 32'(rdy), 32'd1);
    if (sel == 0) begin data_in0 = value; data_in_valid0 = 1'b1; end
    else          begin data_in1 = value; data_in_valid1 = 1'b1; end
    @(posedge clk);
    #1;
    if (sel == 0) begin data_in_valid0 = 1'b0; data_in0 = ~value; end
    else          begin data_in_valid1 = 1'b0; data_in1 = ~value; end
  endtask

  task automatic waitRx(input int sel);
    int waited;
    logic vld;
    waited = 0;
    @(negedge clk);
    vld = (sel == 0) ? data_out_valid0 : data_out_valid1;
    while (vld !== 1'b1 && waited < 30000) begin
      @(negedge clk);
      waited++;
      vld = (sel == 0) ? data_out_valid0 : data_out_valid1;
    end
    checkOutput($sformatf("rx_valid_dut%0d", sel), 32'(vld), 32'd1);
  endtask

  task automatic popOne(input int sel);
    @(negedge clk);
    if (sel == 0) data_out_ready0 = 1'b1; else data_out_ready1 = 1'b1;
    @(negedge clk);
    if (sel == 0) data_out_ready0 = 1'b0; else data_out_ready1 = 1'b0;
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    data_in0 = '0; data_in1 = '0;
    data_in_valid0 = 1'b0; data_in_valid1 = 1'b0;
    data_out_ready0 = 1'b0; data_out_ready1 = 1'b0;
    err_clear0 = 1'b0; err_clear1 = 1'b0;
    loop0 = 1'b1; loop1 = 1'b1; drive0 = 1'b1; drive1 = 1'b1; flip1 = 1'b0;
    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clk);

    checkOutput("rst_serial_out", 32'(serial_out0), 32'd1);
    checkOutput("rst_in_ready", 32'(data_in_ready0), 32'd1);
    checkOutput("rst_out_valid", 32'(data_out_valid0), 32'd0);
    checkOutput("rst_data_out", 32'(data_out0), 32'h00);
    checkOutput("rst_flags", 32'({parity_error0, framing_error0, overrun0}), 32'd0);
    checkOutput("rst_dut1_line_ready", 32'({serial_out1, data_in_ready1, data_out_valid1}), 32'b110);

    $display("[TB] 8N1 loopback of 0x7A");
    applyStimulus(0, 8'h7A);
    lowCount = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (data_in_ready0) break;
      lowCount++;
    end
    checkOutput("tx_busy_cycles", 32'(lowCount), 32'd10850);
    waitRx(0);
    checkOutput("loop_data_7a", 32'(data_out0), 32'h7A);
    checkOutput("loop_flags_7a", 32'({parity_error0, framing_error0, overrun0}), 32'd0);
    popOne(0);
    checkOutput("drained_dut0", 32'(data_out_valid0), 32'd0);

    $display("[TB] 100-cycle glitch while idle");
    drive0 = 1'b1;
    loop0 = 1'b0;
    @(negedge clk);
    drive0 = 1'b0;
    repeat (100) @(negedge clk);
    drive0 = 1'b1;
    repeat (1500) @(negedge clk);
    checkOutput("glitch_valid", 32'(data_out_valid0), 32'd0);
    checkOutput("glitch_flags", 32'({parity_error0, framing_error0, overrun0}), 32'd0);
    loop0 = 1'b1;

    $display("[TB] reset mid-frame then resend");
    applyStimulus(0, 8'hA5);
    repeat (500) @(negedge clk);
    checkOutput("midframe_line", 32'(serial_out0), 32'd0);
    checkOutput("midframe_ready", 32'(data_in_ready0), 32'd0);
    #2;
    reset0 = 1'b1;
    #1;
    checkOutput("async_rst_line", 32'(serial_out0), 32'd1);
    checkOutput("async_rst_ready", 32'(data_in_ready0), 32'd1);
    @(negedge clk);
    reset0 = 1'b0;
    checkOutput("post_rst_valid", 32'(data_out_valid0), 32'd0);
    applyStimulus(0, 8'h3C);
    waitRx(0);
    checkOutput("resend_data_3c", 32'(data_out0), 32'h3C);
    checkOutput("resend_flags", 32'({parity_error0, framing_error0, overrun0}), 32'd0);
    popOne(0);

    $display("[TB] even parity loopback of 0x7A");
    applyStimulus(1, 8'h7A);
    repeat (9 * SET1) @(posedge clk);
    #1;
    checkOutput("parity_bit_line", 32'(serial_out1), 32'd1);
    waitRx(1);
    checkOutput("par_data_7a", 32'(data_out1), 32'h7A);
    checkOutput("par_error_clean", 32'(parity_error1), 32'd0);
    popOne(1);

    $display("[TB] parity bit flipped on the line");
    applyStimulus(1, 8'h7A);
    repeat (9 * SET1) @(posedge clk);
    #1;
    flip1 = 1'b1;
    repeat (SET1) @(posedge clk);
    #1;
    flip1 = 1'b0;
    waitRx(1);
    checkOutput("flip_data_7a", 32'(data_out1), 32'h7A);
    checkOutput("flip_parity_err", 32'(parity_error1), 32'd1);
    checkOutput("flip_framing_err", 32'(framing_error1), 32'd0);
    popOne(1);
    @(negedge clk);
    err_clear1 = 1'b1;
    @(negedge clk);
    err_clear1 = 1'b0;
    checkOutput("clear_parity_err", 32'(parity_error1), 32'd0);

    $display("[TB] overrun with FIFO depth 4");
    for (int v = 1; v <= 5; v++) applyStimulus(1, 8'(v));
    repeat (250) @(negedge clk);
    checkOutput("overrun_set", 32'(overrun1), 32'd1);
    checkOutput("overrun_no_parity", 32'({parity_error1, framing_error1}), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("drain_valid_%0d", k), 32'(data_out_valid1), 32'd1);
      checkOutput($sformatf("drain_data_%0d", k), 32'(data_out1), 32'(k));
      popOne(1);
    end
    checkOutput("drain_empty", 32'(data_out_valid1), 32'd0);
    @(negedge clk);
    err_clear1 = 1'b1;
    @(negedge clk);
    err_clear1 = 1'b0;
    checkOutput("clear_overrun", 32'(overrun1), 32'd0);

    $display("[TB] 0x55 frame with stop bit forced low");
    drive1 = 1'b1;
    loop1 = 1'b0;
    frameBits = {1'b0, 1'b0, 8'h55, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive1 = frameBits[i];
      repeat (SET1) @(negedge clk);
    end
    drive1 = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("frm_valid", 32'(data_out_valid1), 32'd1);
    checkOutput("frm_data_55", 32'(data_out1), 32'h55);
    checkOutput("frm_framing_err", 32'(framing_error1), 32'd1);
    checkOutput("frm_parity_ok", 32'(parity_error1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
